// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter sharing one AXI4-Stream UART transmitter between PORTS requesters.
// Optional UART_TX_ARBITER_ID_HEADER_EN prefixes every packet with a channel-ID byte.
module uart_tx_arbiter #(
  parameter int unsigned PORTS      = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ID_WIDTH   = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [PORTS*DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [PORTS-1:0]              s_axis_tvalid,
  output logic [PORTS-1:0]              s_axis_tready,
  input  logic [PORTS-1:0]              s_axis_tlast,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          busy,
  output logic                          grant_valid,
  output logic [ID_WIDTH-1:0]           grant_index
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
`ifdef UART_TX_ARBITER_ID_HEADER_EN
  localparam logic [1:0] ST_HEADER = 2'd1;
`endif
  localparam logic [1:0] ST_PASS   = 2'd2;

  logic [1:0]            state, state_nxt;
  logic [ID_WIDTH-1:0]   last_grant, last_grant_nxt;
  logic [ID_WIDTH-1:0]   grant_index_nxt;
  logic                  grant_valid_nxt;
  logic [DATA_WIDTH-1:0] m_axis_tdata_nxt;
  logic                  m_axis_tvalid_nxt;

  logic                  out_free;
  logic                  sel_valid;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  accept;
  logic                  req_found;
  logic [ID_WIDTH-1:0]   req_index;

  assign out_free = !m_axis_tvalid || m_axis_tready;
  assign busy     = (state != ST_IDLE) || m_axis_tvalid;

  // Lane of the currently granted port
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int unsigned i = 0; i < PORTS; i++) begin
      if (grant_index == ID_WIDTH'(i)) begin
        sel_valid = s_axis_tvalid[i];
        sel_last  = s_axis_tlast[i];
        sel_data  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Only the granted port sees ready, and only while payload may pass
  always_comb begin
    s_axis_tready = '0;
    for (int unsigned i = 0; i < PORTS; i++) begin
      s_axis_tready[i] = (state == ST_PASS) && (grant_index == ID_WIDTH'(i)) && out_free;
    end
  end

  assign accept = (state == ST_PASS) && sel_valid && out_free;

  // Scan last_grant+1, last_grant+2, ... with wrap; the first valid port wins
  always_comb begin
    req_found = 1'b0;
    req_index = '0;
    for (int unsigned k = 1; k <= PORTS; k++) begin
      for (int unsigned i = 0; i < PORTS; i++) begin
        if (!req_found && s_axis_tvalid[i] &&
            (i == ((32'(last_grant) + k) % PORTS))) begin
          req_found = 1'b1;
          req_index = ID_WIDTH'(i);
        end
      end
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_nxt         = state;
    last_grant_nxt    = last_grant;
    grant_valid_nxt   = grant_valid;
    grant_index_nxt   = grant_index;
    m_axis_tdata_nxt  = m_axis_tdata;
    m_axis_tvalid_nxt = m_axis_tvalid && !m_axis_tready;
    case (state)
      ST_IDLE: begin
        if (req_found) begin
          grant_valid_nxt = 1'b1;
          grant_index_nxt = req_index;
          last_grant_nxt  = req_index;
`ifdef UART_TX_ARBITER_ID_HEADER_EN
          state_nxt       = ST_HEADER;
`else
          state_nxt       = ST_PASS;
`endif
        end
      end
`ifdef UART_TX_ARBITER_ID_HEADER_EN
      ST_HEADER: begin
        if (out_free) begin
          m_axis_tdata_nxt  = DATA_WIDTH'(grant_index);
          m_axis_tvalid_nxt = 1'b1;
          state_nxt         = ST_PASS;
        end
      end
`endif
      ST_PASS: begin
        if (accept) begin
          m_axis_tdata_nxt  = sel_data;
          m_axis_tvalid_nxt = 1'b1;
          if (sel_last) begin
            state_nxt       = ST_IDLE;
            grant_valid_nxt = 1'b0;
            grant_index_nxt = '0;
          end
        end
      end
      default: begin
        state_nxt       = ST_IDLE;
        grant_valid_nxt = 1'b0;
        grant_index_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      last_grant    <= ID_WIDTH'(PORTS - 1);
      grant_valid   <= 1'b0;
      grant_index   <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
    end else begin
      state         <= state_nxt;
      last_grant    <= last_grant_nxt;
      grant_valid   <= grant_valid_nxt;
      grant_index   <= grant_index_nxt;
      m_axis_tdata  <= m_axis_tdata_nxt;
      m_axis_tvalid <= m_axis_tvalid_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: packet-level round-robin model plus per-cycle protocol checks.
module tb_uart_tx_arbiter;
  localparam int P  = 4;
  localparam int DW = 8;
`ifdef UART_TX_ARBITER_ID_HEADER_EN
  localparam bit HDR = 1'b1;
`else
  localparam bit HDR = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [P*DW-1:0] s_tdata;
  logic [P-1:0]    s_tvalid;
  logic [P-1:0]    s_tready;
  logic [P-1:0]    s_tlast;
  logic [DW-1:0]   m_tdata;
  logic            m_tvalid;
  logic            m_tready;
  logic            busy;
  logic            gv;
  logic [1:0]      gi;

  uart_tx_arbiter #(.PORTS(P), .DATA_WIDTH(DW), .ID_WIDTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .busy(busy), .grant_valid(gv), .grant_index(gi)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // per-port stimulus memory: {tlast, data}
  logic [8:0] pmem [P][32];
  int         ptail [P];
  int         head  [P];
  int         mhead [P];
  int         mlast = P - 1;
  logic [P-1:0] in_hs = '0;

  logic [7:0] exp_q[$];
  logic [7:0] olog[$];
  int         ocyc[$];
  logic [7:0] lit[$];
  int         cyc = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_word(input int p, input logic [7:0] d, input logic last);
    pmem[p][ptail[p]] = {last, d};
    ptail[p]++;
  endtask

  // Packet-level round-robin: whole packets in grant order, optional ID byte first
  task automatic model_schedule();
    int p;
    logic [8:0] w;
    for (int n = 0; n < 64; n++) begin
      p = -1;
      for (int k = 1; k <= P; k++)
        if (p < 0 && mhead[(mlast + k) % P] != ptail[(mlast + k) % P]) p = (mlast + k) % P;
      if (p < 0) break;
      if (HDR) exp_q.push_back(8'(p));
      for (int j = 0; j < 32; j++) begin
        w = pmem[p][mhead[p]];
        mhead[p]++;
        exp_q.push_back(w[7:0]);
        if (w[8]) break;
      end
      mlast = p;
    end
  endtask

  task automatic lpk(input int p, input int n, input logic [7:0] b0, input logic [7:0] b1);
    if (HDR) lit.push_back(8'(p));
    lit.push_back(b0);
    if (n > 1) lit.push_back(b1);
  endtask

  task automatic chk_log(input string name);
    chk({name, "_len"}, 32'(olog.size()), 32'(lit.size()));
    for (int i = 0; i < lit.size() && i < olog.size(); i++) chk(name, olog[i], lit[i]);
  endtask

  function automatic bit pending();
    for (int i = 0; i < P; i++) if (head[i] != ptail[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic wait_done(input string name);
    int n = 0;
    while ((pending() || exp_q.size() != 0 || gv || m_tvalid) && n < 400) begin
      @(posedge clk); #2;
      n++;
    end
    chk({name, "_timeout"}, 32'(n < 400), 1);
  endtask

  // Input driver: presents the head word of each port, advances on handshake
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < P; i++) begin
      if (!rst_n) head[i] = ptail[i];
      else if (in_hs[i]) head[i]++;
      s_tvalid[i]        = rst_n && (head[i] != ptail[i]);
      s_tdata[i*DW +: DW] = pmem[i][head[i]][7:0];
      s_tlast[i]         = pmem[i][head[i]][8];
    end
  end

  // Compare process: scoreboard on output handshakes plus protocol rules each cycle
  always @(negedge clk) begin
    in_hs = s_tvalid & s_tready;
    if (rst_n) begin
      if (m_tvalid && m_tready) begin
        olog.push_back(m_tdata);
        ocyc.push_back(cyc);
        chk("sb_word_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) chk("sb_data", m_tdata, exp_q.pop_front());
      end
      if (prev_stall) begin
        chk("hold_valid", m_tvalid, 1);
        chk("hold_data", m_tdata, prev_data);
      end
      if (!gv) begin
        chk("idx_no_grant", gi, 0);
        chk("ready_no_grant", s_tready, 0);
      end else begin
        chk("ready_other_port", s_tready & ~(4'b1 << gi), 0);
        if (m_tvalid && !m_tready) chk("ready_stall", s_tready, 0);
`ifndef UART_TX_ARBITER_ID_HEADER_EN
        chk("ready_grant", s_tready[gi], !m_tvalid || m_tready);
`endif
      end
      chk("busy", busy, gv || m_tvalid);
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
    end else begin
      prev_stall = 1'b0;
    end
    cyc++;
  end

  initial begin
    int n;
    int h0;
    int c0;
    s_tdata = '0; s_tvalid = '0; s_tlast = '0;
    rst_n = 1'b0; m_tready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tdata", m_tdata, 0);
    chk("rst_tready", s_tready, 0);
    chk("rst_gv", gv, 0);
    chk("rst_gi", gi, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;

    // contention: all ports, 2-word packets
    olog.delete(); lit.delete();
    for (int i = 0; i < P; i++) begin
      push_word(i, 8'(8'h10 + i), 1'b0);
      push_word(i, 8'(8'h20 + i), 1'b1);
    end
    model_schedule();
    wait_done("contention");
    for (int i = 0; i < P; i++) lpk(i, 2, 8'(8'h10 + i), 8'(8'h20 + i));
    chk_log("contention_seq");

    // single port 2
    olog.delete(); lit.delete();
    push_word(2, 8'hA5, 1'b0);
    push_word(2, 8'h5A, 1'b1);
    model_schedule();
    n = 0;
    while (!m_tvalid && n < 50) begin @(posedge clk); #2; n++; end
    chk("single_start_timeout", 32'(n < 50), 1);
    chk("single_gv", gv, 1);
    chk("single_gi", gi, 2);
    wait_done("single");
    lpk(2, 2, 8'hA5, 8'h5A);
    chk_log("single_seq");
    if (ocyc.size() >= 2)
      chk("single_consecutive", 32'(ocyc[ocyc.size()-1] - ocyc[ocyc.size()-2]), 1);

    // fairness skip: grant port 0 alone, then 0 and 3 together
    olog.delete(); lit.delete();
    push_word(0, 8'h0A, 1'b1);
    model_schedule();
    wait_done("fair_a");
    push_word(0, 8'h0C, 1'b1);
    push_word(3, 8'h3C, 1'b1);
    model_schedule();
    wait_done("fair_b");
    lpk(0, 1, 8'h0A, 8'h00);
    lpk(3, 1, 8'h3C, 8'h00);
    lpk(0, 1, 8'h0C, 8'h00);
    chk_log("fair_seq");

    // backpressure: 5 cycles of m_tready low mid-packet
    olog.delete(); lit.delete();
    h0 = ptail[1];
    push_word(1, 8'h31, 1'b0);
    push_word(1, 8'h32, 1'b0);
    push_word(1, 8'h33, 1'b0);
    push_word(1, 8'h34, 1'b1);
    model_schedule();
    n = 0;
    while (head[1] != h0 + 2 && n < 50) begin @(posedge clk); #2; n++; end
    chk("bp_start_timeout", 32'(n < 50), 1);
    m_tready = 1'b0;
    chk("bp_pending", m_tvalid, 1);
    repeat (5) @(posedge clk);
    #2;
    chk("bp_held_data", m_tdata, 8'h32);
    chk("bp_no_accept", 32'(head[1] - h0), 2);
    c0 = cyc;
    m_tready = 1'b1;
    @(negedge clk); #1;
    chk("bp_resume", 32'(ocyc[ocyc.size()-1]), 32'(c0));
    wait_done("bp");
    lpk(1, 2, 8'h31, 8'h32);
    lit.push_back(8'h33);
    lit.push_back(8'h34);
    chk_log("bp_seq");

    // single-word packet on port 3 (ID byte only when the header build is used)
    olog.delete(); lit.delete();
    push_word(3, 8'h41, 1'b1);
    model_schedule();
    wait_done("hdr");
    lpk(3, 1, 8'h41, 8'h00);
    chk_log("hdr_seq");

    // reset mid-packet
    olog.delete(); lit.delete();
    h0 = ptail[1];
    push_word(1, 8'h11, 1'b0);
    push_word(1, 8'h12, 1'b0);
    push_word(1, 8'h13, 1'b1);
    model_schedule();
    n = 0;
    while (head[1] != h0 + 2 && n < 50) begin @(posedge clk); #2; n++; end
    chk("rstmid_timeout", 32'(n < 50), 1);
    chk("rstmid_pre_gv", gv, 1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_tvalid", m_tvalid, 0);
    chk("rstmid_tdata", m_tdata, 0);
    chk("rstmid_tready", s_tready, 0);
    chk("rstmid_gv", gv, 0);
    chk("rstmid_gi", gi, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_words_left", 32'(exp_q.size()), 2);
    lpk(1, 1, 8'h11, 8'h00);
    chk_log("rstmid_seq");
    exp_q.delete();
    for (int i = 0; i < P; i++) mhead[i] = ptail[i];
    mlast = P - 1;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    olog.delete(); lit.delete();
    push_word(0, 8'h01, 1'b1);
    push_word(1, 8'h02, 1'b1);
    model_schedule();
    wait_done("post_rst");
    lpk(0, 1, 8'h01, 8'h00);
    lpk(1, 1, 8'h02, 8'h00);
    chk_log("post_rst_seq");

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
